// File: rtl/triangle_setup.sv
// Triangle setup: captures one screen-space triangle, computes its clipped
// bounding box, edge increments and edge values at the box origin using a
// single shared multiplier, culls degenerate/off-screen triangles and hands
// the result to the fragment generator with a one-cycle start pulse.
`timescale 1ns/1ps
module triangle_setup #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_val,
  output logic        tri_rdy,
  input  logic [15:0] x0,
  input  logic [15:0] y0,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  input  logic [15:0] x2,
  input  logic [15:0] y2,
  output logic        fg_start,
  input  logic        fg_done,
  output logic [31:0] fg_xmin,
  output logic [31:0] fg_xmax,
  output logic [31:0] fg_ymin,
  output logic [31:0] fg_ymax,
  output logic [31:0] fg_l0_dx,
  output logic [31:0] fg_l1_dx,
  output logic [31:0] fg_l2_dx,
  output logic [31:0] fg_l0_dy,
  output logic [31:0] fg_l1_dy,
  output logic [31:0] fg_l2_dy,
  output logic [31:0] fg_w0_00,
  output logic [31:0] fg_w1_00,
  output logic [31:0] fg_w2_00,
  output logic        tri_culled,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BBOX    = 3'd1,
    S_MUL     = 3'd2,
    S_CHECK   = 3'd3,
    S_ISSUE   = 3'd4,
    S_WAIT_FG = 3'd5
  } state_t;

  localparam logic signed [31:0] X_LIM = 32'(SCREEN_W);
  localparam logic signed [31:0] Y_LIM = 32'(SCREEN_H);

  function automatic logic signed [31:0] smin(input logic signed [31:0] a, input logic signed [31:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [31:0] smax(input logic signed [31:0] a, input logic signed [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // Orientation fix-up: clockwise triangles get every edge term negated.
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (32'd0 - v) : v;
  endfunction

  state_t state_r, next_state_s;

  logic signed [31:0] x0_r, y0_r, x1_r, y1_r, x2_r, y2_r;
  logic signed [31:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic signed [31:0] hold_r, w0_r, w1_r, w2_r, area_r;
  logic [2:0]         cnt_r;

  logic signed [31:0] xlo_s, xhi_s, ylo_s, yhi_s;
  logic signed [31:0] mult_a_s, mult_b_s, prod_s;
  logic signed [31:0] l0_dx_s, l0_dy_s, l1_dx_s, l1_dy_s, l2_dx_s, l2_dy_s;
  logic               cull_s, neg_s;
  logic               fg_start_s, tri_culled_s, tri_rdy_s, busy_s;

  assign xlo_s = smin(smin(x0_r, x1_r), x2_r);
  assign xhi_s = smax(smax(x0_r, x1_r), x2_r);
  assign ylo_s = smin(smin(y0_r, y1_r), y2_r);
  assign yhi_s = smax(smax(y0_r, y1_r), y2_r);

  // Edge k runs va->vb: dx = yb-ya, dy = xa-xb.
  assign l0_dx_s = y2_r - y1_r;
  assign l0_dy_s = x1_r - x2_r;
  assign l1_dx_s = y0_r - y2_r;
  assign l1_dy_s = x2_r - x0_r;
  assign l2_dx_s = y1_r - y0_r;
  assign l2_dy_s = x0_r - x1_r;

  assign prod_s = mult_a_s * mult_b_s;
  assign cull_s = (area_r == 32'sd0) || (xmin_r >= xmax_r) || (ymin_r >= ymax_r);
  assign neg_s  = area_r[31];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE:    next_state_s = tri_val ? S_BBOX : S_IDLE;
      S_BBOX:    next_state_s = S_MUL;
      S_MUL:     next_state_s = (cnt_r == 3'd7) ? S_CHECK : S_MUL;
      S_CHECK:   next_state_s = cull_s ? S_IDLE : S_ISSUE;
      S_ISSUE:   next_state_s = S_WAIT_FG;
      S_WAIT_FG: next_state_s = fg_done ? S_IDLE : S_WAIT_FG;
      default:   next_state_s = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs.
  always_comb begin
    fg_start_s   = (state_r == S_CHECK) && !cull_s;
    tri_culled_s = (state_r == S_CHECK) && cull_s;
    tri_rdy_s    = (next_state_s == S_IDLE);
    busy_s       = (next_state_s != S_IDLE);
  end

  // Shared multiplier operand schedule: two products per edge value, then area.
  always_comb begin
    mult_a_s = 32'sd0;
    mult_b_s = 32'sd0;
    case (cnt_r)
      3'd0: begin mult_a_s = xmin_r - x1_r; mult_b_s = y2_r - y1_r; end
      3'd1: begin mult_a_s = ymin_r - y1_r; mult_b_s = x2_r - x1_r; end
      3'd2: begin mult_a_s = xmin_r - x2_r; mult_b_s = y0_r - y2_r; end
      3'd3: begin mult_a_s = ymin_r - y2_r; mult_b_s = x0_r - x2_r; end
      3'd4: begin mult_a_s = xmin_r - x0_r; mult_b_s = y1_r - y0_r; end
      3'd5: begin mult_a_s = ymin_r - y0_r; mult_b_s = x1_r - x0_r; end
      3'd6: begin mult_a_s = x0_r - x1_r;   mult_b_s = y2_r - y1_r; end
      3'd7: begin mult_a_s = y0_r - y1_r;   mult_b_s = x2_r - x1_r; end
      default: begin mult_a_s = 32'sd0; mult_b_s = 32'sd0; end
    endcase
  end

  // Datapath: vertex capture, box clipping and product accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r <= 32'sd0; y0_r <= 32'sd0; x1_r <= 32'sd0;
      y1_r <= 32'sd0; x2_r <= 32'sd0; y2_r <= 32'sd0;
      xmin_r <= 32'sd0; xmax_r <= 32'sd0; ymin_r <= 32'sd0; ymax_r <= 32'sd0;
      hold_r <= 32'sd0; w0_r <= 32'sd0; w1_r <= 32'sd0; w2_r <= 32'sd0;
      area_r <= 32'sd0;
      cnt_r  <= 3'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (tri_val) begin
            x0_r <= {{16{x0[15]}}, x0}; y0_r <= {{16{y0[15]}}, y0};
            x1_r <= {{16{x1[15]}}, x1}; y1_r <= {{16{y1[15]}}, y1};
            x2_r <= {{16{x2[15]}}, x2}; y2_r <= {{16{y2[15]}}, y2};
          end
        end
        S_BBOX: begin
          xmin_r <= smax(xlo_s, 32'sd0);
          xmax_r <= smin(xhi_s + 32'sd1, X_LIM);
          ymin_r <= smax(ylo_s, 32'sd0);
          ymax_r <= smin(yhi_s + 32'sd1, Y_LIM);
          cnt_r  <= 3'd0;
        end
        S_MUL: begin
          cnt_r <= cnt_r + 3'd1;
          if (!cnt_r[0]) begin
            hold_r <= prod_s;
          end else begin
            case (cnt_r[2:1])
              2'd0:    w0_r   <= hold_r - prod_s;
              2'd1:    w1_r   <= hold_r - prod_s;
              2'd2:    w2_r   <= hold_r - prod_s;
              default: area_r <= hold_r - prod_s;
            endcase
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Registered outputs; setup results load only on the way into ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fg_start <= 1'b0; tri_culled <= 1'b0; tri_rdy <= 1'b1; busy <= 1'b0;
      fg_xmin <= 32'd0; fg_xmax <= 32'd0; fg_ymin <= 32'd0; fg_ymax <= 32'd0;
      fg_l0_dx <= 32'd0; fg_l1_dx <= 32'd0; fg_l2_dx <= 32'd0;
      fg_l0_dy <= 32'd0; fg_l1_dy <= 32'd0; fg_l2_dy <= 32'd0;
      fg_w0_00 <= 32'd0; fg_w1_00 <= 32'd0; fg_w2_00 <= 32'd0;
    end else begin
      fg_start   <= fg_start_s;
      tri_culled <= tri_culled_s;
      tri_rdy    <= tri_rdy_s;
      busy       <= busy_s;
      if (fg_start_s) begin
        fg_xmin  <= xmin_r;
        fg_xmax  <= xmax_r;
        fg_ymin  <= ymin_r;
        fg_ymax  <= ymax_r;
        fg_l0_dx <= neg_if(neg_s, l0_dx_s);
        fg_l0_dy <= neg_if(neg_s, l0_dy_s);
        fg_l1_dx <= neg_if(neg_s, l1_dx_s);
        fg_l1_dy <= neg_if(neg_s, l1_dy_s);
        fg_l2_dx <= neg_if(neg_s, l2_dx_s);
        fg_l2_dy <= neg_if(neg_s, l2_dy_s);
        fg_w0_00 <= neg_if(neg_s, w0_r);
        fg_w1_00 <= neg_if(neg_s, w1_r);
        fg_w2_00 <= neg_if(neg_s, w2_r);
      end
    end
  end

endmodule
